// File: rtl/krv_dmem_avm_bridge.sv
// KyogenRV data-memory port to Avalon-MM master bridge.
// One outstanding transfer, waitrequest/readdatavalid aware, with timeout abort.
//
// Ports:
//   clock, reset_n            rising-edge clock, async active-low reset
//   cpu_rd_req, cpu_wr_req    CPU request levels, held until served
//   cpu_addr, cpu_wdata,      CPU byte address, write data, byte lanes
//   cpu_byteenable
//   cpu_rd_ack, cpu_rdata     one-cycle read ack, read data held until next ack
//   cpu_waitreq               combinational stall back to the CPU
//   avm_*                     registered Avalon-MM master signals
//   bus_err                   one-cycle pulse on timeout abort or rd+wr collision
module krv_dmem_avm_bridge #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned TIMEOUT = 256,
    parameter logic [DATA_W-1:0] ERR_RDATA = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cpu_rd_req,
    input  logic                cpu_wr_req,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_byteenable,
    output logic                cpu_rd_ack,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_waitreq,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    output logic                bus_err
);

    localparam int unsigned TW =
        (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned TLIM =
        (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [ADDR_W-1:0] AMASK =
        ~ADDR_W'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_RDWAIT,
        S_RESP
    } state_t;

    state_t        state;
    logic          is_rd;
    logic          stale;
    logic [TW-1:0] timer;
    logic          tmo;

    assign tmo = (TIMEOUT != 0) && (timer == TW'(TLIM));

    assign cpu_waitreq =
        (state == S_CMD) || (state == S_RDWAIT) ||
        ((state == S_IDLE) && (cpu_rd_req || cpu_wr_req));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            is_rd          <= 1'b0;
            stale          <= 1'b0;
            timer          <= '0;
            cpu_rd_ack     <= 1'b0;
            cpu_rdata      <= '0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            bus_err        <= 1'b0;
        end else begin
            cpu_rd_ack <= 1'b0;
            bus_err    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // late data of an aborted read
                    if (stale && avm_readdatavalid)
                        stale <= 1'b0;
                    if (cpu_rd_req || cpu_wr_req) begin
                        avm_address    <= cpu_addr & AMASK;
                        avm_writedata  <= cpu_wdata;
                        avm_byteenable <= cpu_byteenable;
                        // write wins a collision
                        avm_write      <= cpu_wr_req;
                        avm_read       <= !cpu_wr_req;
                        is_rd          <= !cpu_wr_req;
                        bus_err        <= cpu_wr_req && cpu_rd_req;
                        timer          <= '0;
                        state          <= S_CMD;
                    end
                end
                S_CMD: begin
                    timer <= timer + 1'b1;
                    if (stale && avm_readdatavalid)
                        stale <= 1'b0;
                    if (!avm_waitrequest) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        if (!is_rd) begin
                            state <= S_RESP;
                        end else if (avm_readdatavalid && !stale) begin
                            // zero-latency slave: data in accept cycle
                            cpu_rdata  <= avm_readdata;
                            cpu_rd_ack <= 1'b1;
                            state      <= S_RESP;
                        end else begin
                            timer <= '0;
                            state <= S_RDWAIT;
                        end
                    end else if (tmo) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        bus_err   <= 1'b1;
                        state     <= S_RESP;
                        if (is_rd) begin
                            cpu_rdata  <= ERR_RDATA;
                            cpu_rd_ack <= 1'b1;
                        end
                    end
                end
                S_RDWAIT: begin
                    timer <= timer + 1'b1;
                    if (avm_readdatavalid && !stale) begin
                        cpu_rdata  <= avm_readdata;
                        cpu_rd_ack <= 1'b1;
                        state      <= S_RESP;
                    end else if (tmo) begin
                        // accepted read still owes a beat
                        cpu_rdata  <= ERR_RDATA;
                        cpu_rd_ack <= 1'b1;
                        bus_err    <= 1'b1;
                        stale      <= 1'b1;
                        state      <= S_RESP;
                    end else if (avm_readdatavalid) begin
                        stale <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (stale && avm_readdatavalid)
                        stale <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_krv_dmem_avm_bridge.sv
// Directed bench for krv_dmem_avm_bridge.
// Read data is checked through an expected-data queue popped on each rd_ack.
module tb_krv_dmem_avm_bridge;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cpu_rd_req, cpu_wr_req;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_byteenable;
    logic        cpu_rd_ack, cpu_waitreq;
    logic [31:0] cpu_rdata;
    logic [31:0] avm_address, avm_writedata;
    logic        avm_read, avm_write;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest, avm_readdatavalid;
    logic [31:0] avm_readdata;
    logic        bus_err;

    logic        b_rd_req, b_wr_req;
    logic        b_rd_ack, b_waitreq;
    logic [31:0] b_rdata, b_address, b_writedata;
    logic        b_read, b_write;
    logic [3:0]  b_byteenable;
    logic        b_waitrequest, b_rdv;
    logic        b_bus_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    krv_dmem_avm_bridge #(
        .DATA_W(32), .ADDR_W(32), .TIMEOUT(8),
        .ERR_RDATA(32'h0)
    ) u_dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_byteenable(cpu_byteenable),
        .cpu_rd_ack(cpu_rd_ack), .cpu_rdata(cpu_rdata),
        .cpu_waitreq(cpu_waitreq),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .bus_err(bus_err)
    );

    krv_dmem_avm_bridge #(
        .DATA_W(32), .ADDR_W(32), .TIMEOUT(0),
        .ERR_RDATA(32'h0)
    ) u_dut0 (
        .clock(clock), .reset_n(reset_n),
        .cpu_rd_req(b_rd_req), .cpu_wr_req(b_wr_req),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_byteenable(cpu_byteenable),
        .cpu_rd_ack(b_rd_ack), .cpu_rdata(b_rdata),
        .cpu_waitreq(b_waitreq),
        .avm_address(b_address), .avm_read(b_read),
        .avm_write(b_write), .avm_writedata(b_writedata),
        .avm_byteenable(b_byteenable),
        .avm_waitrequest(b_waitrequest),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(b_rdv),
        .bus_err(b_bus_err)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic samp();
        @(negedge clock);
    endtask

    // scoreboard: every rd_ack must match the oldest expected word
    always @(negedge clock) begin
        if (cpu_rd_ack === 1'b1) begin
            logic [31:0] e;
            e = 'x;
            if (exp_q.size() > 0)
                e = exp_q.pop_front();
            chk("sb_rdata", cpu_rdata, e);
        end
    end

    initial begin
        int good;
        reset_n = 1'b0;
        cpu_rd_req = 0; cpu_wr_req = 0;
        cpu_addr = 0; cpu_wdata = 0; cpu_byteenable = 0;
        avm_waitrequest = 0; avm_readdatavalid = 0;
        avm_readdata = 0;
        b_rd_req = 0; b_wr_req = 0;
        b_waitrequest = 0; b_rdv = 0;

        // reset state
        samp();
        chk("rst_read", avm_read, 0);
        chk("rst_write", avm_write, 0);
        chk("rst_ack", cpu_rd_ack, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_waitreq", cpu_waitreq, 0);
        chk("rst_b_read", b_read, 0);
        nxt();
        nxt();
        reset_n = 1'b1;

        // read @0x1004, zero-wait slave, rdv one after accept
        nxt();
        cpu_rd_req = 1; cpu_addr = 32'h0000_1004;
        exp_q.push_back(32'hCAFE_F00D);
        samp();
        chk("rd_n_waitreq", cpu_waitreq, 1);
        chk("rd_n_read", avm_read, 0);
        nxt();
        samp();
        chk("rd_n1_read", avm_read, 1);
        chk("rd_n1_addr", avm_address, 32'h1004);
        nxt();
        avm_readdatavalid = 1; avm_readdata = 32'hCAFE_F00D;
        samp();
        chk("rd_n2_read", avm_read, 0);
        chk("rd_n2_ack", cpu_rd_ack, 0);
        nxt();
        avm_readdatavalid = 0;
        samp();
        chk("rd_n3_ack", cpu_rd_ack, 1);
        chk("rd_n3_waitreq", cpu_waitreq, 0);
        nxt();
        cpu_rd_req = 0;
        samp();
        chk("rd_after_ack", cpu_rd_ack, 0);
        chk("rd_hold", cpu_rdata, 32'hCAFE_F00D);

        // write @0x2003 be=1000, waitrequest high 3 cycles
        nxt();
        cpu_wr_req = 1; cpu_addr = 32'h0000_2003;
        cpu_wdata = 32'h1122_3344; cpu_byteenable = 4'b1000;
        avm_waitrequest = 1;
        samp();
        for (int i = 1; i <= 4; i++) begin
            nxt();
            if (i == 4) avm_waitrequest = 0;
            samp();
            chk("wr_write", avm_write, 1);
            chk("wr_addr", avm_address, 32'h2000);
            chk("wr_data", avm_writedata, 32'h1122_3344);
            chk("wr_be", avm_byteenable, 4'b1000);
            chk("wr_waitreq", cpu_waitreq, 1);
        end
        nxt();
        samp();
        chk("wr_done_write", avm_write, 0);
        chk("wr_done_waitreq", cpu_waitreq, 0);
        chk("wr_no_ack", cpu_rd_ack, 0);
        nxt();
        cpu_wr_req = 0;

        // timeout of an accepted read
        nxt();
        cpu_rd_req = 1; cpu_addr = 32'h0000_3000;
        exp_q.push_back(32'h0);
        samp();
        nxt();
        samp();
        chk("to_read", avm_read, 1);
        for (int i = 2; i <= 9; i++) begin
            nxt();
            samp();
            chk("to_wait_err", bus_err, 0);
            chk("to_wait_stall", cpu_waitreq, 1);
        end
        nxt();
        samp();
        chk("to_err", bus_err, 1);
        chk("to_ack", cpu_rd_ack, 1);
        chk("to_rdata", cpu_rdata, 32'h0);
        nxt();
        cpu_rd_req = 0;
        samp();
        chk("to_err_pulse", bus_err, 0);

        // next read ignores the late beat of the aborted one
        nxt();
        cpu_rd_req = 1; cpu_addr = 32'h0000_3008;
        exp_q.push_back(32'h5555_AAAA);
        samp();
        nxt();
        samp();
        nxt();
        avm_readdatavalid = 1; avm_readdata = 32'h0000_1234;
        samp();
        nxt();
        avm_readdata = 32'h5555_AAAA;
        samp();
        chk("stale_no_ack", cpu_rd_ack, 0);
        nxt();
        avm_readdatavalid = 0;
        samp();
        chk("stale_ack", cpu_rd_ack, 1);
        nxt();
        cpu_rd_req = 0;

        // rd+wr collision
        nxt();
        cpu_rd_req = 1; cpu_wr_req = 1;
        cpu_addr = 32'h0000_4000; cpu_wdata = 32'hDEAD_BEEF;
        cpu_byteenable = 4'b1111;
        samp();
        nxt();
        samp();
        chk("col_write", avm_write, 1);
        chk("col_read", avm_read, 0);
        chk("col_err", bus_err, 1);
        nxt();
        samp();
        chk("col_err_pulse", bus_err, 0);
        chk("col_no_ack", cpu_rd_ack, 0);
        chk("col_waitreq", cpu_waitreq, 0);
        nxt();
        cpu_rd_req = 0; cpu_wr_req = 0;

        // reset while a read is stalled in CMD
        nxt();
        cpu_rd_req = 1; cpu_addr = 32'h0000_5000;
        avm_waitrequest = 1;
        samp();
        nxt();
        samp();
        chk("rst_cmd_read", avm_read, 1);
        nxt();
        reset_n = 0;
        #1;
        chk("rst_async_read", avm_read, 0);
        chk("rst_async_rdata", cpu_rdata, 0);
        nxt();
        reset_n = 1; cpu_rd_req = 0; avm_waitrequest = 0;
        for (int i = 0; i < 3; i++) begin
            nxt();
            samp();
            chk("rst_post_ack", cpu_rd_ack, 0);
            chk("rst_post_read", avm_read, 0);
        end

        // read after reset
        nxt();
        cpu_rd_req = 1; cpu_addr = 32'h0000_5004;
        exp_q.push_back(32'hA5A5_0001);
        samp();
        nxt();
        samp();
        chk("post_addr", avm_address, 32'h5004);
        nxt();
        avm_readdatavalid = 1; avm_readdata = 32'hA5A5_0001;
        samp();
        nxt();
        avm_readdatavalid = 0;
        samp();
        chk("post_ack", cpu_rd_ack, 1);
        nxt();
        cpu_rd_req = 0;

        // TIMEOUT=0 instance: 1000 stalled cycles, no abort
        nxt();
        b_rd_req = 1; b_waitrequest = 1;
        cpu_addr = 32'h0000_6000;
        samp();
        good = 0;
        for (int i = 0; i < 1000; i++) begin
            nxt();
            samp();
            if (b_read === 1'b1 && b_bus_err === 1'b0 &&
                b_waitreq === 1'b1)
                good++;
        end
        chk("t0_hold", good, 1000);
        nxt();
        b_waitrequest = 0;
        samp();
        nxt();
        b_rdv = 1; avm_readdata = 32'h0BAD_CAFE;
        samp();
        chk("t0_read_drop", b_read, 0);
        nxt();
        b_rdv = 0;
        samp();
        chk("t0_ack", b_rd_ack, 1);
        chk("t0_rdata", b_rdata, 32'h0BAD_CAFE);
        chk("t0_err", b_bus_err, 0);
        nxt();
        b_rd_req = 0;

        nxt();
        samp();
        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
